// File: rtl/dataint_crc_frame_ctrl.sv
// Frame sequencer in front of a cascaded CRC engine: streams beats into the
// engine, waits for its registered CRC, and returns {crc, byte length}.
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   s_valid/s_ready       input beat handshake
//   s_data/s_bytes/s_last beat payload, tail lane count, end of frame
//   i_abort               drop the frame in progress
//   o_load_crc_start      engine seed pulse
//   o_load_from_cascade   engine load strobe
//   o_cascade_sel         one-hot lane count select (bit n-1 = n bytes)
//   o_data                engine data (pass-through of s_data)
//   i_crc                 engine registered CRC
//   m_valid/m_ready       result handshake
//   m_crc/m_len           captured CRC and saturating frame byte count
module dataint_crc_frame_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int CHUNKS     = DATA_WIDTH / 8,
  parameter int CRC_WIDTH  = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic [$clog2(CHUNKS+1)-1:0]  s_bytes,
  input  logic                         s_last,
  input  logic                         i_abort,
  output logic                         o_load_crc_start,
  output logic                         o_load_from_cascade,
  output logic [CHUNKS-1:0]            o_cascade_sel,
  output logic [DATA_WIDTH-1:0]        o_data,
  input  logic [CRC_WIDTH-1:0]         i_crc,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [CRC_WIDTH-1:0]         m_crc,
  output logic [LEN_WIDTH-1:0]         m_len
);

  localparam int NW = $clog2(CHUNKS + 1);
  localparam int SW = ((LEN_WIDTH > NW) ? LEN_WIDTH : NW) + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, FLUSH, CAPT, RESULT
  } state_e;

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [CRC_WIDTH-1:0]   m_crc_q, m_crc_d;
  logic [LEN_WIDTH-1:0]   m_len_q, m_len_d;
  logic                   m_valid_q, m_valid_d;

  logic [NW-1:0]          n;
  logic [SW-1:0]          sum;
  logic [LEN_WIDTH-1:0]   len_sat;
  logic                   acc;

  // Lanes carried by the current beat; tail counts above CHUNKS clamp.
  always_comb begin
    n = NW'(CHUNKS);
    if (s_last && (s_bytes < NW'(CHUNKS))) begin
      n = s_bytes;
    end
  end

  always_comb begin
    sum     = SW'(len_q) + SW'(n);
    len_sat = (sum > SW'(LEN_MAX)) ? LEN_MAX : LEN_WIDTH'(sum);
  end

  // Abort wins over the beat: no accept and no engine strobe this cycle.
  assign s_ready             = (state_q == DATA) && !i_abort;
  assign acc                 = s_valid && s_ready;
  assign o_load_crc_start    = (state_q == START) && !i_abort;
  assign o_load_from_cascade = acc && (n != '0);
  assign o_data              = s_data;

  always_comb begin
    o_cascade_sel = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      o_cascade_sel[i] = o_load_from_cascade && (n == NW'(i + 1));
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    m_crc_d   = m_crc_q;
    m_len_d   = m_len_q;
    m_valid_d = m_valid_q;
    unique case (state_q)
      IDLE: begin
        if (s_valid) state_d = START;
      end
      START: begin
        len_d   = '0;
        state_d = i_abort ? IDLE : DATA;
      end
      DATA: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (acc) begin
          len_d = len_sat;
          if (s_last) state_d = FLUSH;
        end
      end
      // Engine register is updating; its output flop lags one more cycle.
      FLUSH: begin
        state_d = i_abort ? IDLE : CAPT;
      end
      CAPT: begin
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          m_crc_d   = i_crc;
          m_len_d   = len_q;
          m_valid_d = 1'b1;
          state_d   = RESULT;
        end
      end
      RESULT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      m_crc_q   <= '0;
      m_len_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      m_crc_q   <= m_crc_d;
      m_len_q   <= m_len_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_crc   = m_crc_q;
  assign m_len   = m_len_q;

endmodule
